// File: rtl/atr_switch_sequencer_if.sv
// ============================================================================
//  Module   : atr_switch_sequencer_if
//  Brief    : Settings bus, run flags and ATR/ready outputs of the sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface atr_switch_sequencer_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        run_rx;
    logic        run_tx;
    logic        atr_rx;
    logic        atr_tx;
    logic        rx_ready;
    logic        tx_ready;
    logic        busy;
    logic [31:0] status;

    modport master (
        output set_stb, set_addr, set_data, run_rx, run_tx,
        input  atr_rx, atr_tx, rx_ready, tx_ready, busy, status
    );

    modport slave (
        input  set_stb, set_addr, set_data, run_rx, run_tx,
        output atr_rx, atr_tx, rx_ready, tx_ready, busy, status
    );
endinterface

`default_nettype wire

// File: rtl/atr_switch_sequencer.sv
// ============================================================================
//  Module   : atr_switch_sequencer
//  Brief    : Break-before-make RF switch sequencer with guard/settle timing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module atr_switch_sequencer #(
    parameter int          BASE           = 0,
    parameter logic [15:0] DEFAULT_GUARD  = 16'd32,
    parameter logic [15:0] DEFAULT_SETTLE = 16'd64
) (
    input logic                    clk,
    input logic                    reset,
    atr_switch_sequencer_if.slave  bus
);

    localparam logic [7:0] c_addr_guard  = 8'(BASE);
    localparam logic [7:0] c_addr_settle = 8'(BASE + 1);
    localparam logic [7:0] c_addr_ctrl   = 8'(BASE + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        MAKE   = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    logic [15:0] r_guard;
    logic [15:0] r_settle;
    logic        r_enable;
    logic        r_fdx_allow;
    logic [1:0]  r_req;

    state_t      r_state;
    logic [1:0]  r_cur_mode;
    logic [15:0] r_count;
    logic [1:0]  r_atr;
    logic [1:0]  r_ready;
    logic        r_busy;

    logic [1:0]  w_target;
    state_t      w_make_state;
    logic [1:0]  w_make_ready;
    state_t      w_state_nxt;
    logic [1:0]  w_mode_nxt;
    logic [15:0] w_count_nxt;
    logic [1:0]  w_atr_nxt;
    logic [1:0]  w_ready_nxt;
    logic        w_unused_data;

    assign w_unused_data = &{1'b0, bus.set_data[31:16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_guard     <= DEFAULT_GUARD;
            r_settle    <= DEFAULT_SETTLE;
            r_enable    <= 1'b1;
            r_fdx_allow <= 1'b1;
            r_req       <= 2'b00;
        end else begin
            r_req <= {bus.run_tx, bus.run_rx};
            if (bus.set_stb) begin
                if (bus.set_addr == c_addr_guard)
                    r_guard <= bus.set_data[15:0];
                if (bus.set_addr == c_addr_settle)
                    r_settle <= bus.set_data[15:0];
                if (bus.set_addr == c_addr_ctrl) begin
                    r_enable    <= bus.set_data[0];
                    r_fdx_allow <= bus.set_data[1];
                end
            end
        end
    end

    // Full duplex is only granted when allowed; otherwise TX takes the switch.
    always_comb begin
        w_target = r_req;
        if (r_req == 2'b11 && !r_fdx_allow)
            w_target = 2'b10;
    end

    // A zero settle time skips MAKE and grants ready on the same edge.
    assign w_make_state = (r_settle == 16'd0) ? ACTIVE : MAKE;
    assign w_make_ready = (r_settle == 16'd0) ? w_target : 2'b00;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_cur_mode;
        w_count_nxt = r_count;
        w_atr_nxt   = r_atr;
        w_ready_nxt = r_ready;

        if (!r_enable) begin
            w_state_nxt = IDLE;
            w_mode_nxt  = 2'b00;
            w_count_nxt = 16'd0;
            w_atr_nxt   = w_target;
            w_ready_nxt = w_target;
        end else if (r_state != IDLE && w_target == 2'b00) begin
            w_state_nxt = IDLE;
            w_mode_nxt  = 2'b00;
            w_count_nxt = 16'd0;
            w_atr_nxt   = 2'b00;
            w_ready_nxt = 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    w_mode_nxt  = 2'b00;
                    w_count_nxt = 16'd0;
                    w_atr_nxt   = 2'b00;
                    w_ready_nxt = 2'b00;
                    if (w_target != 2'b00) begin
                        w_state_nxt = w_make_state;
                        w_mode_nxt  = w_target;
                        w_count_nxt = r_settle;
                        w_atr_nxt   = w_target;
                        w_ready_nxt = w_make_ready;
                    end
                end
                BREAK: begin
                    w_atr_nxt   = 2'b00;
                    w_ready_nxt = 2'b00;
                    // The mode made is whatever the target is when the guard expires.
                    if (r_count <= 16'd1) begin
                        w_state_nxt = w_make_state;
                        w_mode_nxt  = w_target;
                        w_count_nxt = r_settle;
                        w_atr_nxt   = w_target;
                        w_ready_nxt = w_make_ready;
                    end else begin
                        w_count_nxt = r_count - 16'd1;
                    end
                end
                default: begin
                    if (w_target != r_cur_mode) begin
                        if (r_guard == 16'd0) begin
                            w_state_nxt = w_make_state;
                            w_mode_nxt  = w_target;
                            w_count_nxt = r_settle;
                            w_atr_nxt   = w_target;
                            w_ready_nxt = w_make_ready;
                        end else begin
                            w_state_nxt = BREAK;
                            w_count_nxt = r_guard;
                            w_atr_nxt   = 2'b00;
                            w_ready_nxt = 2'b00;
                        end
                    end else if (r_state == MAKE) begin
                        if (r_count <= 16'd1) begin
                            w_state_nxt = ACTIVE;
                            w_count_nxt = 16'd0;
                            w_ready_nxt = r_cur_mode;
                        end else begin
                            w_count_nxt = r_count - 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cur_mode <= 2'b00;
            r_count    <= 16'd0;
            r_atr      <= 2'b00;
            r_ready    <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_mode <= w_mode_nxt;
            r_count    <= w_count_nxt;
            r_atr      <= w_atr_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= (w_state_nxt == BREAK) || (w_state_nxt == MAKE);
        end
    end

    assign bus.atr_rx   = r_atr[0];
    assign bus.atr_tx   = r_atr[1];
    assign bus.rx_ready = r_ready[0];
    assign bus.tx_ready = r_ready[1];
    assign bus.busy     = r_busy;
    assign bus.status   = {12'd0, r_state, r_cur_mode, r_count};

endmodule

`default_nettype wire

// File: tb/tb_atr_switch_sequencer.sv
// ============================================================================
//  Module   : tb_atr_switch_sequencer
//  Brief    : Directed self-checking bench for atr_switch_sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atr_switch_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    atr_switch_sequencer_if bus_if ();

    atr_switch_sequencer #(
        .BASE           (0),
        .DEFAULT_GUARD  (16'd32),
        .DEFAULT_SETTLE (16'd64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus_if.set_stb  = 1'b1;
        bus_if.set_addr = addr;
        bus_if.set_data = data;
        tick();
        bus_if.set_stb  = 1'b0;
    endtask

    function automatic logic [31:0] st(input logic [1:0] s, input logic [1:0] m,
                                        input logic [15:0] c);
        return {12'd0, s, m, c};
    endfunction

    // Expected vector layout: {atr_tx, atr_rx, tx_ready, rx_ready, busy}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus_if.atr_tx, bus_if.atr_rx, bus_if.tx_ready, bus_if.rx_ready, bus_if.busy};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (bus_if.status === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, bus_if.status, exp);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus_if.set_stb  = 1'b0;
        bus_if.set_addr = 8'd0;
        bus_if.set_data = 32'd0;
        bus_if.run_rx   = 1'b0;
        bus_if.run_tx   = 1'b0;
        tick(2);
        chk_out("reset_out", 5'b00_00_0);
        chk_st("reset_status", 32'd0);
        reset = 1'b0;
        tick();

        // IDLE -> TX, guard 4 settle 3
        wr(8'd0, 32'd4);
        wr(8'd1, 32'd3);
        bus_if.run_tx = 1'b1;
        tick();
        chk_out("tx_e0", 5'b00_00_0);
        tick();
        chk_out("tx_e1", 5'b10_00_1);
        chk_st("tx_e1_status", st(2'd2, 2'b10, 16'd3));
        tick(2);
        chk_out("tx_e3", 5'b10_00_1);
        tick();
        chk_out("tx_e4", 5'b10_10_0);
        chk_st("tx_e4_status", st(2'd3, 2'b10, 16'd0));

        // Asynchronous reset mid-ACTIVE
        #2 reset = 1'b1;
        #1;
        chk_out("async_reset_out", 5'b00_00_0);
        chk_st("async_reset_status", 32'd0);
        bus_if.run_tx = 1'b0;
        reset = 1'b0;

        // Defaults restored: settle 64, guard 32
        bus_if.run_tx = 1'b1;
        tick(2);
        chk_out("dflt_e1", 5'b10_00_1);
        chk_st("dflt_settle_load", st(2'd2, 2'b10, 16'd64));
        tick(63);
        chk_out("dflt_e64", 5'b10_00_1);
        tick();
        chk_out("dflt_e65", 5'b10_10_0);
        bus_if.run_tx = 1'b0;
        bus_if.run_rx = 1'b1;
        tick();
        chk_out("dguard_e0", 5'b10_10_0);
        tick();
        chk_out("dguard_e1", 5'b00_00_1);
        tick(31);
        chk_out("dguard_e32", 5'b00_00_1);
        tick();
        chk_out("dguard_e33", 5'b01_00_1);

        // Register writes during MAKE leave the running count alone
        wr(8'd0, 32'd4);
        wr(8'd1, 32'd2);
        tick(61);
        chk_out("midwrite_e96", 5'b01_00_1);
        tick();
        chk_out("midwrite_e97", 5'b01_01_0);

        // RX -> TX break, guard 4 settle 2
        bus_if.run_rx = 1'b0;
        bus_if.run_tx = 1'b1;
        tick(2);
        chk_out("rxtx_e1", 5'b00_00_1);
        tick(3);
        chk_out("rxtx_e4", 5'b00_00_1);
        tick();
        chk_out("rxtx_e5", 5'b10_00_1);
        tick();
        chk_out("rxtx_e6", 5'b10_00_1);
        tick();
        chk_out("rxtx_e7", 5'b10_10_0);

        // Drop to idle without guard
        bus_if.run_tx = 1'b0;
        tick(2);
        chk_out("drop_e1", 5'b00_00_0);

        // FDX gating
        wr(8'd2, 32'd1);
        bus_if.run_rx = 1'b1;
        bus_if.run_tx = 1'b1;
        tick(2);
        chk_out("fdx_off_e1", 5'b10_00_1);
        tick(2);
        chk_out("fdx_off_e3", 5'b10_10_0);
        chk_st("fdx_off_status", st(2'd3, 2'b10, 16'd0));
        wr(8'd2, 32'd3);
        tick();
        chk_out("fdx_on_break", 5'b00_00_1);
        tick(4);
        chk_out("fdx_on_make", 5'b11_00_1);
        tick(2);
        chk_out("fdx_on_active", 5'b11_11_0);

        // Abort mid-MAKE
        bus_if.run_rx = 1'b0;
        bus_if.run_tx = 1'b0;
        tick(2);
        wr(8'd1, 32'd10);
        bus_if.run_tx = 1'b1;
        tick(4);
        bus_if.run_tx = 1'b0;
        tick();
        chk_out("abort_e4", 5'b10_00_1);
        chk_st("abort_e4_status", st(2'd2, 2'b10, 16'd7));
        tick();
        chk_out("abort_e5", 5'b00_00_0);
        chk_st("abort_e5_status", 32'd0);
        tick(10);
        chk_out("abort_later", 5'b00_00_0);

        // Zero guard and settle
        wr(8'd0, 32'd0);
        wr(8'd1, 32'd0);
        bus_if.run_rx = 1'b1;
        tick(2);
        chk_out("zero_rx_e1", 5'b01_01_0);
        chk_st("zero_rx_status", st(2'd3, 2'b01, 16'd0));
        bus_if.run_rx = 1'b0;
        bus_if.run_tx = 1'b1;
        tick(2);
        chk_out("zero_tx_e1", 5'b10_10_0);

        // Bypass
        wr(8'd1, 32'd3);
        wr(8'd2, 32'd0);
        bus_if.run_tx = 1'b0;
        bus_if.run_rx = 1'b1;
        tick();
        chk_out("byp_e0", 5'b10_10_0);
        tick();
        chk_out("byp_rx_on", 5'b01_01_0);
        chk_st("byp_status", 32'd0);
        bus_if.run_rx = 1'b0;
        tick(2);
        chk_out("byp_rx_off", 5'b00_00_0);
        bus_if.run_rx = 1'b1;
        tick(2);
        chk_out("byp_rx_on2", 5'b01_01_0);

        // Re-enable with run_rx held high
        wr(8'd2, 32'd3);
        tick();
        chk_out("reen_make", 5'b01_00_1);
        chk_st("reen_status", st(2'd2, 2'b01, 16'd3));
        tick(3);
        chk_out("reen_active", 5'b01_01_0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
